// File: rtl/pcie4_cfg_msix_req_arb.sv
// ============================================================================
// Module   : pcie4_cfg_msix_req_arb
// Brief    : Round-robin arbiter that funnels per-channel MSI-X requests into
//            the single PCIe core interrupt port, with retry and timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie4_cfg_msix_req_arb #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_FUNCTION_NUMBER = 0,
    parameter int C_MAX_RETRY       = 3,
    parameter int C_TIMEOUT_CYCLES  = 1024
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [C_NUM_CHANNELS-1:0]      s_req,
    input  logic [C_NUM_CHANNELS*64-1:0]   s_address,
    input  logic [C_NUM_CHANNELS*32-1:0]   s_data,
    output logic [C_NUM_CHANNELS-1:0]      s_ack,
    output logic [C_NUM_CHANNELS-1:0]      s_err,
    input  logic                           m_enable,
    input  logic                           m_mask,
    output logic                           m_int_vector,
    output logic [63:0]                    m_address,
    output logic [31:0]                    m_data,
    output logic [7:0]                     m_function_number,
    input  logic                           m_sent,
    input  logic                           m_fail
);

    localparam int C_IDX_W = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                      r_state;
    logic [C_NUM_CHANNELS-1:0]   r_pending;
    logic [C_IDX_W-1:0]          r_ptr;
    logic [C_IDX_W-1:0]          r_grant;
    logic                        r_repeat;
    logic [3:0]                  r_retry;
    logic [15:0]                 r_timer;

    logic [C_NUM_CHANNELS-1:0]   w_rot;
    logic                        w_found;
    logic [C_IDX_W-1:0]          w_off;
    logic [C_IDX_W:0]            w_sum;
    logic [C_IDX_W-1:0]          w_grant;
    logic [C_IDX_W-1:0]          w_next_ptr;
    logic [C_NUM_CHANNELS-1:0]   w_grant_oh;
    logic                        w_go;
    logic                        w_timeout;
    logic                        w_can_retry;
    logic                        w_done;
    logic [C_NUM_CHANNELS-1:0]   w_pend_clr;

    assign m_function_number = 8'(C_FUNCTION_NUMBER);

    // Rotate pending so that bit 0 is the channel where the search starts.
    assign w_rot = C_NUM_CHANNELS'({r_pending, r_pending} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = C_NUM_CHANNELS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = C_IDX_W'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_grant    = (w_sum >= (C_IDX_W+1)'(C_NUM_CHANNELS))
                      ? C_IDX_W'(w_sum - (C_IDX_W+1)'(C_NUM_CHANNELS))
                      : w_sum[C_IDX_W-1:0];
    assign w_next_ptr = (w_grant == C_IDX_W'(C_NUM_CHANNELS - 1))
                      ? '0 : w_grant + C_IDX_W'(1);
    assign w_grant_oh = C_NUM_CHANNELS'(1) << r_grant;

    assign w_go        = w_found && m_enable && !m_mask;
    assign w_timeout   = (r_timer >= 16'(C_TIMEOUT_CYCLES - 1));
    assign w_can_retry = (r_retry < 4'(C_MAX_RETRY)) && m_enable && !m_mask;
    assign w_done      = (r_state == ST_WAIT) &&
                         (m_sent || ((m_fail || w_timeout) && !w_can_retry));
    // A request seen for the in-service channel keeps its pending bit alive.
    assign w_pend_clr  = (w_done && !r_repeat) ? w_grant_oh : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_repeat     <= 1'b0;
            r_retry      <= '0;
            r_timer      <= '0;
            m_int_vector <= 1'b0;
            s_ack        <= '0;
            s_err        <= '0;
            m_address    <= '0;
            m_data       <= '0;
        end else begin
            s_ack     <= '0;
            s_err     <= '0;
            r_pending <= (r_pending & ~w_pend_clr) | s_req;

            if (r_state == ST_IDLE) begin
                r_repeat <= 1'b0;
            end else if ((s_req & w_grant_oh) != '0) begin
                r_repeat <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_grant      <= w_grant;
                        r_ptr        <= w_next_ptr;
                        m_address    <= s_address[w_grant*64 +: 64];
                        m_data       <= s_data[w_grant*32 +: 32];
                        m_int_vector <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    m_int_vector <= 1'b0;
                    r_timer      <= '0;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_timer != 16'hFFFF) begin
                        r_timer <= r_timer + 16'd1;
                    end
                    if (m_sent) begin
                        s_ack   <= w_grant_oh;
                        r_retry <= '0;
                        r_state <= ST_IDLE;
                    end else if (m_fail || w_timeout) begin
                        if (w_can_retry) begin
                            r_retry      <= r_retry + 4'd1;
                            m_int_vector <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end else begin
                            s_err   <= w_grant_oh;
                            r_retry <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    m_int_vector <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/pcie4_cfg_msix_req_arb.md
PCIE4_CFG_MSIX_REQ_ARB -- requirements
Module: pcie4_cfg_msix_req_arb

Interface
REQ-001 SHALL have parameter C_NUM_CHANNELS, default 4, number of interrupt request channels (legal 1..16).
REQ-002 SHALL have parameter C_FUNCTION_NUMBER, default 0, value driven on m_function_number (8 bit).
REQ-003 SHALL have parameter C_MAX_RETRY, default 3, retries after m_fail before dropping (legal 0..15).
REQ-004 SHALL have parameter C_TIMEOUT_CYCLES, default 1024, WAIT cycles before a request counts as failed (legal 2..65535).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports aclk and aresetn.
REQ-006 SHALL have port aclk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port s_req, input, C_NUM_CHANNELS, per-channel single-cycle request pulse.
REQ-009 SHALL have port s_address, input, C_NUM_CHANNELS*64, per-channel MSI-X address (channel i at [64i+63:64i]).
REQ-010 SHALL have port s_data, input, C_NUM_CHANNELS*32, per-channel MSI-X data (channel i at [32i+31:32i]).
REQ-011 SHALL have port s_ack, output, C_NUM_CHANNELS, one-cycle pulse: channel's message sent.
REQ-012 SHALL have port s_err, output, C_NUM_CHANNELS, one-cycle pulse: channel's message dropped.
REQ-013 SHALL have port m_enable, input, 1, MSI-X enable of the function.
REQ-014 SHALL have port m_mask, input, 1, MSI-X function mask.
REQ-015 SHALL have port m_int_vector, output, 1, one-cycle request to the PCIe core.
REQ-016 SHALL have port m_address, output, 64, address of the message in flight.
REQ-017 SHALL have port m_data, output, 32, data of the message in flight.
REQ-018 SHALL have port m_function_number, output, 8, constant C_FUNCTION_NUMBER.
REQ-019 SHALL have port m_sent, input, 1, core pulse: message sent.
REQ-020 SHALL have port m_fail, input, 1, core pulse: message failed.

Function
REQ-021 SHALL hold a pending bit per channel, set by s_req, cleared when s_ack or s_err for that channel pulses.
REQ-022 SHALL coalesce s_req on an already-pending, not-in-service channel; no second message.
REQ-023 SHALL, if s_req arrives for the in-service channel, keep its pending bit set after completion, producing one further message; set wins over clear in the same cycle.
REQ-024 SHALL run FSM IDLE -> ISSUE -> WAIT -> IDLE; ISSUE lasts exactly one cycle.
REQ-025 SHALL leave IDLE only when any pending bit is set, m_enable=1 and m_mask=0; otherwise stay IDLE with pending bits held.
REQ-026 SHALL grant round-robin: search starts at channel (last granted + 1) mod C_NUM_CHANNELS; after reset the search starts at channel 0.
REQ-027 SHALL, on grant, latch the channel index, s_address and s_data of that channel; m_address/m_data hold the latched values until the next grant.
REQ-028 SHALL assert m_int_vector=1 only in ISSUE; IDLE to m_int_vector latency one cycle after the enabling condition is sampled.
REQ-029 SHALL, in WAIT, on m_sent: pulse s_ack of the granted channel next cycle, reset the retry count, go IDLE.
REQ-030 SHALL, in WAIT, on m_fail or timeout counter reaching C_TIMEOUT_CYCLES: if retry count < C_MAX_RETRY, increment it and return to ISSUE; else pulse s_err, reset the retry count, go IDLE.
REQ-031 SHALL treat m_sent and m_fail in the same cycle as m_sent; ignore both outside WAIT.
REQ-032 SHALL restart the timeout counter (16 bit, saturating) on every entry to WAIT.
REQ-033 SHALL let a message already in WAIT complete if m_enable falls or m_mask rises; retries are suppressed and it is dropped with s_err instead.

Reset
REQ-034 SHALL, while aresetn=0, asynchronously force: state IDLE, pending bits 0, retry and timeout counters 0, round-robin pointer to channel 0, m_int_vector 0, s_ack 0, s_err 0, m_address 0, m_data 0.
REQ-035 SHALL abandon any in-flight message on reset without s_ack/s_err, and ignore m_sent/m_fail until the next ISSUE.

Verification
REQ-036 SHALL cover: s_req[2]=1 with m_enable=1, m_mask=0, addr 0xFEE0_0000, data 0x41 -> m_int_vector pulse carrying those values; m_sent 5 cycles later -> s_ack[2] single pulse.
REQ-037 SHALL cover: s_req=4'b1111 in one cycle -> grants 0,1,2,3 in order, each completed by m_sent, exactly four s_ack pulses.
REQ-038 SHALL cover: C_MAX_RETRY=3, m_fail on every attempt -> four m_int_vector pulses, then s_err[0] pulse, pending[0] cleared.
REQ-039 SHALL cover: m_mask=1 while s_req[1] pulses -> no m_int_vector; m_mask to 0 -> exactly one message issued.
REQ-040 SHALL cover: core silent, C_TIMEOUT_CYCLES=16, C_MAX_RETRY=0 -> s_err after 16 cycles in WAIT.
REQ-041 SHALL cover: aresetn low during WAIT, then high with m_sent pulse -> no s_ack, all outputs 0.
